// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG register arbiter.
//   arb_state_e : arbiter FSM state
//   ID_SEL      : TCR select value that reads the ID word
//   ID_VAL      : ID word returned for ID_SEL
//   BAD_VAL     : value returned for an unmapped select
package jtag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_J = 2'd1,
    ST_GNT_U = 2'd2
  } arb_state_e;

  localparam logic [7:0]  ID_SEL  = 8'hFF;
  localparam logic [31:0] ID_VAL  = 32'hDEAD_BEEF;
  localparam logic [31:0] BAD_VAL = 32'hBEEF_BEEF;

endpackage

// File: rtl/sync_pulse.sv
// Multi-flop synchronizer for one asynchronous bit, with an optional
// registered rising-edge pulse output.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : EDGE=1 -> one-cycle pulse per rising edge of d
//              EDGE=0 -> synchronized level of d
module sync_pulse #(
  parameter int unsigned STAGES = 2,
  parameter bit          EDGE   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Edge-detecting chains reset high so a level held high through reset
  // (or low afterwards) never looks like a rising edge.
  localparam logic RST_VAL = EDGE;

  logic [STAGES-1:0] sync_q;

  // Synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  if (EDGE) begin : g_edge
    logic prev_q;
    logic pulse_q;

    // Registered rising-edge detect
    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q  <= 1'b1;
        pulse_q <= 1'b0;
      end else begin
        prev_q  <= sync_q[STAGES-1];
        pulse_q <= sync_q[STAGES-1] & ~prev_q;
      end
    end

    assign q = pulse_q;
  end else begin : g_level
    assign q = sync_q[STAGES-1];
  end

endmodule

// File: rtl/jtag_reg_arbiter.sv
// Shares a register bank between the JTAG EXTEST data path and a local
// user requester. TAP events are synchronized into clk, the TCR select
// byte is decoded, and single-cycle accesses are round-robin arbitrated.
//   clk, rst          : system clock, synchronous active-high reset
//   capture_dr_i      : TAP capture_dr (async) -> JTAG read request
//   update_dr_i       : TAP update_dr (async)  -> JTAG write request
//   extest_sel_i      : EXTEST loaded (async), gates JTAG events
//   tcr_sel_i/tcr_wr_i: TCR select byte and write enable (quasi-static)
//   jtag_wdata_i      : JTAG write data;  jtag_rdata_o : JTAG read data
//   usr_*             : user request/grant/read-valid handshake
//   reg_q_o           : flattened bank, reg i at [i*DATA_W +: DATA_W]
//   err_o             : sticky error
module jtag_reg_arbiter
  import jtag_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SEL_W       = 8,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          capture_dr_i,
  input  logic                          update_dr_i,
  input  logic                          extest_sel_i,
  input  logic [SEL_W-1:0]              tcr_sel_i,
  input  logic                          tcr_wr_i,
  input  logic [DATA_W-1:0]             jtag_wdata_i,
  output logic [DATA_W-1:0]             jtag_rdata_o,
  input  logic                          usr_req_i,
  input  logic                          usr_we_i,
  input  logic [$clog2(NUM_REGS)-1:0]   usr_addr_i,
  input  logic [DATA_W-1:0]             usr_wdata_i,
  output logic                          usr_gnt_o,
  output logic [DATA_W-1:0]             usr_rdata_o,
  output logic                          usr_rvalid_o,
  output logic [NUM_REGS*DATA_W-1:0]    reg_q_o,
  output logic                          err_o
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic cap_ev;
  logic upd_ev;
  logic extest_s;

  sync_pulse #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_cap (
    .clk (clk), .rst (rst), .d (capture_dr_i), .q (cap_ev)
  );

  sync_pulse #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_upd (
    .clk (clk), .rst (rst), .d (update_dr_i), .q (upd_ev)
  );

  sync_pulse #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_ext (
    .clk (clk), .rst (rst), .d (extest_sel_i), .q (extest_s)
  );

  logic [DATA_W-1:0] bank_q [NUM_REGS];
  arb_state_e        state_q;
  logic              jpend_rd_q;
  logic              jpend_wr_q;
  logic              last_j_q;

  logic              sel_in_bank_c;
  logic              sel_is_id_c;
  logic [AW-1:0]     sel_idx_c;
  logic              usr_addr_ok_c;
  logic [DATA_W-1:0] jtag_dec_c;
  logic              jpend_c;
  logic              clr_rd_c;
  logic              clr_wr_c;
  logic              jrd_ev_c;
  logic              jwr_ev_c;

  // Select decode and JTAG read mux
  always_comb begin
    sel_in_bank_c = 32'(tcr_sel_i) < NUM_REGS;
    sel_is_id_c   = tcr_sel_i == SEL_W'(ID_SEL);
    sel_idx_c     = AW'(tcr_sel_i);
    usr_addr_ok_c = 32'(usr_addr_i) < NUM_REGS;
    if (sel_in_bank_c)    jtag_dec_c = bank_q[sel_idx_c];
    else if (sel_is_id_c) jtag_dec_c = DATA_W'(ID_VAL);
    else                  jtag_dec_c = DATA_W'(BAD_VAL);
  end

  // Pending-flag bookkeeping; a write pending is always served first
  always_comb begin
    jpend_c  = jpend_rd_q | jpend_wr_q;
    clr_wr_c = (state_q == ST_GNT_J) &&  jpend_wr_q;
    clr_rd_c = (state_q == ST_GNT_J) && !jpend_wr_q;
    jrd_ev_c = cap_ev & extest_s;
    jwr_ev_c = upd_ev & extest_s & tcr_wr_i;
  end

  // Arbiter FSM, bank and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_j_q     <= 1'b0;
      jpend_rd_q   <= 1'b0;
      jpend_wr_q   <= 1'b0;
      jtag_rdata_o <= '0;
      usr_rdata_o  <= '0;
      usr_gnt_o    <= 1'b0;
      usr_rvalid_o <= 1'b0;
      err_o        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else begin
      usr_gnt_o    <= 1'b0;
      usr_rvalid_o <= 1'b0;

      if (clr_rd_c) jpend_rd_q <= 1'b0;
      if (clr_wr_c) jpend_wr_q <= 1'b0;
      // A flag being served this cycle can take a fresh event without error
      if (jrd_ev_c) begin
        jpend_rd_q <= 1'b1;
        if (jpend_rd_q && !clr_rd_c) err_o <= 1'b1;
      end
      if (jwr_ev_c) begin
        jpend_wr_q <= 1'b1;
        if (jpend_wr_q && !clr_wr_c) err_o <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          // On contention grant whoever was not granted last
          if (jpend_c && (!usr_req_i || !last_j_q)) begin
            state_q  <= ST_GNT_J;
            last_j_q <= 1'b1;
          end else if (usr_req_i) begin
            state_q   <= ST_GNT_U;
            last_j_q  <= 1'b0;
            usr_gnt_o <= 1'b1;
          end
        end

        ST_GNT_J: begin
          state_q <= ST_IDLE;
          if (jpend_wr_q) begin
            if (sel_in_bank_c)     bank_q[sel_idx_c] <= jtag_wdata_i;
            else if (!sel_is_id_c) err_o <= 1'b1;
          end else begin
            jtag_rdata_o <= jtag_dec_c;
            if (!sel_in_bank_c && !sel_is_id_c) err_o <= 1'b1;
          end
        end

        ST_GNT_U: begin
          state_q <= ST_IDLE;
          if (usr_we_i) begin
            if (usr_addr_ok_c) bank_q[usr_addr_i] <= usr_wdata_i;
            else               err_o <= 1'b1;
          end else begin
            usr_rvalid_o <= 1'b1;
            if (usr_addr_ok_c) begin
              usr_rdata_o <= bank_q[usr_addr_i];
            end else begin
              usr_rdata_o <= '0;
              err_o       <= 1'b1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Flattened bank view
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q_o[i*DATA_W +: DATA_W] = bank_q[i];
  end

endmodule
